// File: rtl/div_sign_seq.sv
// ---------------------------------------------------------------------------
// div_sign_seq -- sequential signed fixed-point divider, q = a / b.
//
// The quotient magnitude is built by radix-2 restoring division, one bit per
// clock over the operand magnitudes. The sign is then applied with truncation
// toward zero, and the result saturates on overflow or divide-by-zero.
// Operands use the same INTn.FRQn convention as the Goertzel multiplier.
// Latency is constant at N+1 clocks from the accepting edge, where N = DW+SH.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   a_in       signed dividend  (INT1_I.FRQ1_I)
//   b_in       signed divisor   (INT2_I.FRQ2_I)
//   valid_in   operands valid; transfer = valid_in & ready_out
//   ready_out  high only while idle
//   q_out      signed quotient  (INT3_O.FRQ3_O), held until the next result
//   valid_out  one-cycle pulse that marks a new q_out and new flags
//   ovf_out    the result saturated because of overflow
//   dz_out     the divisor was zero
// ---------------------------------------------------------------------------
module div_sign_seq #(
   parameter int DW     = 32,
   parameter int INT1_I = 16,
   parameter int INT2_I = 16,
   parameter int INT3_O = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   input  logic          valid_in,
   output logic          ready_out,
   output logic [DW-1:0] q_out,
   output logic          valid_out,
   output logic          ovf_out,
   output logic          dz_out
);

   localparam int FRQ1_I = DW - INT1_I;
   localparam int FRQ2_I = DW - INT2_I;
   localparam int FRQ3_O = DW - INT3_O;
   // The dividend is pre-shifted so that the integer quotient lands directly in the output Q-format.
   localparam int SH     = FRQ3_O - FRQ1_I + FRQ2_I;
   localparam int NW     = DW + SH;
   localparam int CW     = (NW > 1) ? $clog2(NW) : 1;

   localparam logic [CW-1:0] CNT_INIT = CW'(NW - 1);
   localparam logic [DW-1:0] MAX_POS  = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
   localparam logic [NW-1:0] Q_HALF   = {{(NW-1){1'b0}}, 1'b1} << (DW - 1);

   if (SH < 0) begin : g_sh_check
      $error("div_sign_seq: FRQ3_O - FRQ1_I + FRQ2_I must be >= 0");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            sign_q, sign_d;
   logic            sa_q, sa_d;
   logic            dz_q, dz_d;
   logic [DW-1:0]   bmag_q, bmag_d;
   logic [NW-1:0]   dvd_q, dvd_d;
   logic [NW-1:0]   quo_q, quo_d;
   logic [DW:0]     rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   q_q, q_d;
   logic            vld_q, vld_d;
   logic            ovf_q, ovf_d;
   logic            dzo_q, dzo_d;

   logic            xfer_s;
   logic [DW-1:0]   amag_s;
   logic [DW-1:0]   bmag_s;
   logic [NW-1:0]   amag_ext_s;
   logic [DW:0]     rem_sh_s;
   logic            rem_ge_s;
   logic            quo_big_s;
   logic            rem_top_unused_s;

   assign xfer_s    = valid_in & (state_q == ST_IDLE);
   assign ready_out = (state_q == ST_IDLE);
   assign q_out     = q_q;
   assign valid_out = vld_q;
   assign ovf_out   = ovf_q;
   assign dz_out    = dzo_q;

   // The stored remainder is always below |b| <= 2^(DW-1), so its top bit stays zero.
   // The bit exists only to keep the width of the trial subtraction.
   assign rem_top_unused_s = rem_q[DW];

   // Compute the magnitudes as unsigned values; -2^(DW-1) maps exactly to 2^(DW-1).
   always_comb begin
      amag_s     = a_in[DW-1] ? -a_in : a_in;
      bmag_s     = b_in[DW-1] ? -b_in : b_in;
      amag_ext_s = '0;
      amag_ext_s[DW-1:0] = amag_s;
   end

   // One restoring step: shift in the next dividend bit, then subtract |b| if it fits.
   always_comb begin
      rem_sh_s  = {rem_q[DW-1:0], dvd_q[NW-1]};
      rem_ge_s  = (rem_sh_s >= {1'b0, bmag_q});
      quo_big_s = |quo_q[NW-1:DW-1];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer_s) begin
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_FIX:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next-state values for each FSM state.
   always_comb begin
      sign_d = sign_q;
      sa_d   = sa_q;
      dz_d   = dz_q;
      bmag_d = bmag_q;
      dvd_d  = dvd_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      cnt_d  = cnt_q;
      q_d    = q_q;
      vld_d  = 1'b0;
      ovf_d  = ovf_q;
      dzo_d  = dzo_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer_s) begin
               sign_d = a_in[DW-1] ^ b_in[DW-1];
               sa_d   = a_in[DW-1];
               dz_d   = (b_in == '0);
               bmag_d = bmag_s;
               dvd_d  = amag_ext_s << SH;
               quo_d  = '0;
               rem_d  = '0;
               cnt_d  = CNT_INIT;
            end else begin
               cnt_d  = cnt_q;
            end
         end
         ST_CALC: begin
            dvd_d = dvd_q << 1;
            if (rem_ge_s) begin
               rem_d = rem_sh_s - {1'b0, bmag_q};
               quo_d = {quo_q[NW-2:0], 1'b1};
            end else begin
               rem_d = rem_sh_s;
               quo_d = {quo_q[NW-2:0], 1'b0};
            end
            if (cnt_q != '0) begin
               cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_FIX: begin
            vld_d = 1'b1;
            if (dz_q) begin
               q_d   = sa_q ? MIN_NEG : MAX_POS;
               ovf_d = 1'b0;
               dzo_d = 1'b1;
            end else if (!sign_q && quo_big_s) begin
               q_d   = MAX_POS;
               ovf_d = 1'b1;
               dzo_d = 1'b0;
            end else if (sign_q && quo_big_s && (quo_q != Q_HALF)) begin
               q_d   = MIN_NEG;
               ovf_d = 1'b1;
               dzo_d = 1'b0;
            end else begin
               // A magnitude of exactly 2^(DW-1) with a negative sign negates back onto itself.
               q_d   = sign_q ? -quo_q[DW-1:0] : quo_q[DW-1:0];
               ovf_d = 1'b0;
               dzo_d = 1'b0;
            end
         end
         default: begin
            vld_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q <= 1'b0;
         sa_q   <= 1'b0;
         dz_q   <= 1'b0;
         bmag_q <= '0;
         dvd_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         q_q    <= '0;
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
         dzo_q  <= 1'b0;
      end else begin
         sign_q <= sign_d;
         sa_q   <= sa_d;
         dz_q   <= dz_d;
         bmag_q <= bmag_d;
         dvd_q  <= dvd_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         q_q    <= q_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
         dzo_q  <= dzo_d;
      end
   end

endmodule

// File: tb/tb_div_sign_seq.sv
// ---------------------------------------------------------------------------
// tb_div_sign_seq -- directed self-checking bench for div_sign_seq with the
// Q8.8 configuration (DW=16, SH=8, N=24, latency 25 clocks).
// ---------------------------------------------------------------------------
module tb_div_sign_seq;

   localparam int DW  = 16;
   localparam int LAT = 25;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] a_in;
   logic [DW-1:0] b_in;
   logic          valid_in;
   logic          ready_out;
   logic [DW-1:0] q_out;
   logic          valid_out;
   logic          ovf_out;
   logic          dz_out;

   int total;
   int bad;

   div_sign_seq #(
      .DW     (16),
      .INT1_I (8),
      .INT2_I (8),
      .INT3_O (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_in      (a_in),
      .b_in      (b_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .q_out     (q_out),
      .valid_out (valid_out),
      .ovf_out   (ovf_out),
      .dz_out    (dz_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one operand pair, then measure the latency and check the result.
   task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_q, input logic exp_ovf, input logic exp_dz);
      int cnt;
      @(negedge clk);
      a_in     = a;
      b_in     = b;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      a_in     = 16'h1234;
      b_in     = 16'h0000;
      cnt = 0;
      while (valid_out !== 1'b1 && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk({tag, "_lat"}, 32'(cnt), 32'(LAT));
      chk({tag, "_q"}, {16'h0, q_out}, {16'h0, exp_q});
      chk({tag, "_ovf"}, {31'h0, ovf_out}, {31'h0, exp_ovf});
      chk({tag, "_dz"}, {31'h0, dz_out}, {31'h0, exp_dz});
      chk({tag, "_rdy"}, {31'h0, ready_out}, 32'h1);
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, {31'h0, valid_out}, 32'h0);
   endtask

   initial begin
      int cnt;
      int seen;
      total    = 0;
      bad      = 0;
      rst_n    = 1'b0;
      a_in     = 16'h0;
      b_in     = 16'h0;
      valid_in = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_q", {16'h0, q_out}, 32'h0);
      chk("rst_valid", {31'h0, valid_out}, 32'h0);
      chk("rst_ovf", {31'h0, ovf_out}, 32'h0);
      chk("rst_dz", {31'h0, dz_out}, 32'h0);
      chk("rst_ready", {31'h0, ready_out}, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      do_div("d3by2",    16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0);
      do_div("dm3by2",   16'hFD00, 16'h0200, 16'hFE80, 1'b0, 1'b0);
      do_div("d1by3",    16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0);
      do_div("dm1by3",   16'hFF00, 16'h0300, 16'hFFAB, 1'b0, 1'b0);
      do_div("ovf_pos",  16'h6400, 16'h0080, 16'h7FFF, 1'b1, 1'b0);
      do_div("ovf_min",  16'h8000, 16'hFF00, 16'h7FFF, 1'b1, 1'b0);
      do_div("min_ok",   16'h8000, 16'h0100, 16'h8000, 1'b0, 1'b0);
      do_div("dz_neg",   16'hFF00, 16'h0000, 16'h8000, 1'b0, 1'b1);
      do_div("dz_pos",   16'h0100, 16'h0000, 16'h7FFF, 1'b0, 1'b1);

      // valid_in held high; operands changed while busy must be ignored.
      @(negedge clk);
      a_in     = 16'h0300;
      b_in     = 16'h0200;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      a_in = 16'h0100;
      b_in = 16'h0000;
      cnt  = 0;
      while (valid_out !== 1'b1 && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("bb1_lat", 32'(cnt), 32'(LAT));
      chk("bb1_q", {16'h0, q_out}, 32'h0180);
      chk("bb1_dz", {31'h0, dz_out}, 32'h0);
      a_in = 16'h0100;
      b_in = 16'h0300;
      cnt  = 0;
      while ((valid_out !== 1'b1 || cnt == 0) && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
         if (cnt == 1) begin
            a_in = 16'h6400;
            b_in = 16'h0080;
         end else begin
            a_in = a_in;
         end
         if (cnt == 12) begin
            chk("bb_hold_q", {16'h0, q_out}, 32'h0180);
            chk("bb_busy_rdy", {31'h0, ready_out}, 32'h0);
         end else begin
            a_in = a_in;
         end
      end
      chk("bb2_period", 32'(cnt), 32'(LAT + 1));
      chk("bb2_q", {16'h0, q_out}, 32'h0055);
      chk("bb2_ovf", {31'h0, ovf_out}, 32'h0);
      valid_in = 1'b0;
      @(posedge clk);
      #1;

      // Reset asserted in the middle of CALC abandons the operation.
      @(negedge clk);
      a_in     = 16'h0300;
      b_in     = 16'h0200;
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_q", {16'h0, q_out}, 32'h0);
      chk("mid_rst_ready", {31'h0, ready_out}, 32'h1);
      chk("mid_rst_valid", {31'h0, valid_out}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (valid_out === 1'b1) begin
            seen++;
         end else begin
            seen = seen;
         end
      end
      chk("mid_rst_no_valid", 32'(seen), 32'h0);
      do_div("after_rst", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
